jc_seq_ctrl: RTL and testbench

JC_SEQ_CTRL -- requirements
Module: jc_seq_ctrl

---
 rtl/jc_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_jc_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jc_seq_ctrl.sv
// Two-requester round-robin Johnson-counter step-burst sequencer.
// Optional per-burst step prescaler: define JC_SEQ_CTRL_PRESCALE_EN.
//
// state | meaning
// IDLE  | waiting for a request; grants combinationally and latches len/dir
// RUN   | stepping o_Q once per tick until the burst length is exhausted or aborted
// DONE  | one-cycle completion pulse (o_done, qualified by o_aborted)
module jc_seq_ctrl #(
  parameter int W     = 3,
  parameter int LEN_W = 8,
  parameter int PRE_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  input  logic             i_dir0,
  input  logic             i_dir1,
  input  logic             i_abort,
`ifdef JC_SEQ_CTRL_PRESCALE_EN
  input  logic [PRE_W-1:0] i_presc,
`endif
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic             o_owner,
  output logic             o_done,
  output logic             o_aborted,
  output logic [W-1:0]     o_Q
);

  if (W < 2 || LEN_W < 1 || PRE_W < 1) begin : g_bad_param
    $error("jc_seq_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [W-1:0]     q_q;
  logic [LEN_W-1:0] rem_q;
  logic             dir_q;
  logic             prio_q;
  logic             owner_q;
  logic             abort_q;
  logic             gnt_idx;
  logic             grant;
  logic             step_tick;
  logic             do_step;

  // Both requesting: the favoured one wins; otherwise whoever is asking.
  assign gnt_idx = (i_req == 2'b11) ? prio_q : ~i_req[0];
  assign grant   = (state_q == S_IDLE) && (|i_req);

`ifdef JC_SEQ_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] phase_q;

  assign step_tick = (phase_q == '0);

  // Phase down-counter: a step fires on terminal count, then reloads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      phase_q <= '0;
    end else if (grant) begin
      presc_q <= i_presc;
      phase_q <= i_presc;
    end else if (state_q == S_RUN && !i_abort) begin
      phase_q <= step_tick ? presc_q : phase_q - 1'b1;
    end
  end
`else
  assign step_tick = 1'b1;
`endif

  always_comb begin
    state_n = state_q;
    o_gnt   = 2'b00;
    do_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|i_req) begin
          o_gnt   = gnt_idx ? 2'b10 : 2'b01;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort || rem_q == '0) begin
          state_n = S_DONE;
        end else if (step_tick) begin
          do_step = 1'b1;
          if (rem_q == LEN_W'(1)) state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (grant) begin
        rem_q   <= gnt_idx ? i_len1 : i_len0;
        dir_q   <= gnt_idx ? i_dir1 : i_dir0;
        owner_q <= gnt_idx;
        prio_q  <= ~gnt_idx;
        abort_q <= 1'b0;
      end
      if (state_q == S_RUN && i_abort) abort_q <= 1'b1;
      if (do_step) begin
        q_q   <= dir_q ? {q_q[W-2:0], ~q_q[W-1]} : {~q_q[0], q_q[W-1:1]};
        rem_q <= rem_q - 1'b1;
      end
    end
  end

  assign o_busy    = (state_q == S_RUN);
  assign o_done    = (state_q == S_DONE);
  assign o_aborted = (state_q == S_DONE) && abort_q;
  assign o_owner   = owner_q;
  assign o_Q       = q_q;

endmodule

// File: tb/tb_jc_seq_ctrl.sv
// Bench for jc_seq_ctrl: directed scenarios plus randomized bursts against a
// burst-level model (Johnson state as a position on the 2W-state ring).
module tb_jc_seq_ctrl;
  localparam int W     = 3;
  localparam int LEN_W = 8;
  localparam int PRE_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [1:0]       i_req = 2'b00;
  logic [LEN_W-1:0] i_len0 = '0, i_len1 = '0;
  logic             i_dir0 = 1'b0, i_dir1 = 1'b0;
  logic             i_abort = 1'b0;
  logic [1:0]       o_gnt;
  logic             o_busy, o_owner, o_done, o_aborted;
  logic [W-1:0]     o_Q;
`ifdef JC_SEQ_CTRL_PRESCALE_EN
  logic [PRE_W-1:0] presc_sel = '0;
`endif

  jc_seq_ctrl #(.W(W), .LEN_W(LEN_W), .PRE_W(PRE_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_len0(i_len0), .i_len1(i_len1), .i_dir0(i_dir0), .i_dir1(i_dir1),
    .i_abort(i_abort),
`ifdef JC_SEQ_CTRL_PRESCALE_EN
    .i_presc(presc_sel),
`endif
    .o_gnt(o_gnt), .o_busy(o_busy), .o_owner(o_owner), .o_done(o_done),
    .o_aborted(o_aborted), .o_Q(o_Q)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int m_idx  = 0;   // ring position of o_Q: 0 = all zeros, forward = +1
  int m_pref = 0;   // requester that wins a tie

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] q_of(input int idx);
    int k;
    k = ((idx % (2*W)) + 2*W) % (2*W);
    if (k <= W) return ((1 << k) - 1) << (W - k);
    return (1 << (2*W - k)) - 1;
  endfunction

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_req = 2'b00; i_abort = 1'b0;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
    m_idx = 0; m_pref = 0;
  endtask

  // One full burst: grant cycle, RUN cycles, DONE cycle. abort_at is the
  // 1-based RUN cycle in which i_abort is high (0 = never).
  task automatic run_burst(input logic [1:0] req, input int l0, input int l1,
                           input logic d0, input logic d1, input int abort_at,
                           input bit abort_in_done);
    int win, len, step_sgn, p, r, run_len, done_steps, sb;
    bit ab;
    i_req = req; i_len0 = LEN_W'(l0); i_len1 = LEN_W'(l1);
    i_dir0 = d0; i_dir1 = d1; i_abort = 1'b0;
    win = (req == 2'b11) ? m_pref : (req[0] ? 0 : 1);
    m_pref = 1 - win;
    len = win ? l1 : l0;
    step_sgn = (win ? d1 : d0) ? -1 : 1;
`ifdef JC_SEQ_CTRL_PRESCALE_EN
    p = int'(presc_sel);
`else
    p = 0;
`endif
    r = (len == 0) ? 1 : len * (p + 1);
    ab = (abort_at >= 1) && (abort_at <= r);
    run_len = ab ? abort_at : r;
    @(negedge i_clk);
    chk("gnt", o_gnt, win ? 2 : 1);
    chk("idle_busy", o_busy, 0);
    next_cycle();
    for (int c = 1; c <= run_len; c++) begin
      i_abort = ab && (c == abort_at);
      sb = (c - 1) / (p + 1);
      if (sb > len) sb = len;
      @(negedge i_clk);
      chk("run_q", o_Q, q_of(m_idx + step_sgn * sb));
      chk("run_busy", o_busy, 1);
      chk("run_gnt", o_gnt, 0);
      chk("run_done", o_done, 0);
      chk("run_owner", o_owner, win);
      next_cycle();
    end
    done_steps = ab ? (abort_at - 1) / (p + 1) : len;
    if (done_steps > len) done_steps = len;
    m_idx = m_idx + step_sgn * done_steps;
    i_abort = abort_in_done;
    @(negedge i_clk);
    chk("done", o_done, 1);
    chk("aborted", o_aborted, ab);
    chk("done_busy", o_busy, 0);
    chk("done_gnt", o_gnt, 0);
    chk("done_q", o_Q, q_of(m_idx));
    next_cycle();
    i_abort = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    i_req = 2'b00;
    @(negedge i_clk);
    chk({tag, "_gnt"}, o_gnt, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_q"}, o_Q, q_of(m_idx));
    next_cycle();
  endtask

  initial begin
    do_reset();
    @(negedge i_clk);
    chk("rst_q", o_Q, 0);
    chk("rst_gnt", o_gnt, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_aborted", o_aborted, 0);
    chk("rst_owner", o_owner, 0);
    next_cycle();

    // Forward 3 steps: 100, 110, 111.
    run_burst(2'b01, 3, 0, 1'b0, 1'b0, 0, 1'b0);
    chk("t1_q", o_Q, 3'b111);
    // Reverse 2 steps from 111: 110, 100.
    run_burst(2'b10, 0, 2, 1'b0, 1'b1, 0, 1'b0);
    chk("t2_q", o_Q, 3'b100);
    chk("t2_owner", o_owner, 1);
    // Full ring (6 steps) returns to start; then a zero-length burst.
    run_burst(2'b01, 6, 0, 1'b0, 1'b0, 0, 1'b0);
    chk("t3_ring", o_Q, 3'b100);
    run_burst(2'b01, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    idle_check("t3_idle");

    // Round robin with both requests held from reset.
    do_reset();
    run_burst(2'b11, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    run_burst(2'b11, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    run_burst(2'b11, 1, 1, 1'b0, 1'b0, 0, 1'b0);
    chk("t4_owner", o_owner, 0);

    // Abort in 4th RUN cycle of a 10-step burst: 3 steps taken.
    do_reset();
    run_burst(2'b01, 10, 0, 1'b0, 1'b0, 4, 1'b0);
    chk("t5_q", o_Q, 3'b111);
    // Abort coinciding with the final step: abort wins.
    run_burst(2'b01, 2, 0, 1'b1, 1'b0, 2, 1'b0);
    chk("t5_last_q", o_Q, 3'b110);

    // Reset mid-burst: no done pulse, state cleared.
    i_req = 2'b01; i_len0 = LEN_W'(10); i_dir0 = 1'b0;
    next_cycle();
    i_req = 2'b00;
    next_cycle(); next_cycle(); next_cycle();
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("t6_pre_busy", o_busy, 1);
    next_cycle();
    i_rst = 1'b0;
    m_idx = 0; m_pref = 0;
    @(negedge i_clk);
    chk("t6_q", o_Q, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_done", o_done, 0);
    chk("t6_owner", o_owner, 0);
    next_cycle();
    idle_check("t6_idle");

`ifdef JC_SEQ_CTRL_PRESCALE_EN
    presc_sel = PRE_W'(2);
    run_burst(2'b01, 2, 0, 1'b0, 1'b0, 0, 1'b0);
    chk("t6_presc_q", o_Q, 3'b110);
    run_burst(2'b10, 0, 3, 1'b0, 1'b1, 5, 1'b0);
`endif

    for (int n = 0; n < 80; n++) begin
      logic [1:0] rq;
      int ab_at;
      rq = 2'($urandom_range(1, 3));
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : 0;
`ifdef JC_SEQ_CTRL_PRESCALE_EN
      presc_sel = PRE_W'($urandom_range(0, 3));
`endif
      run_burst(rq, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ab_at, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle_check("rnd_idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
